// File: rtl/cpuc_bus_arbiter.sv
// Round-robin owner of the shared CPUC tristate data bus: one-hot driver enables,
// a programmable dead gap between owners, and a tenure cap while others wait.
module cpuc_bus_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_HOLD  = 8,
  parameter int TA_CYCLES = 1,
  localparam int IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] tri_en,
  output logic [IDW-1:0]     owner_id,
  output logic               owner_vld,
  output logic [1:0]         state_dbg
);

  localparam int HCW = $clog2(MAX_HOLD + 1);
  localparam int TCW = (TA_CYCLES > 1) ? $clog2(TA_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_TURN  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [IDW-1:0]     rr_q, rr_d;
  logic [HCW-1:0]     hold_q, hold_d;
  logic [TCW-1:0]     ta_q, ta_d;

  logic                 win_vld;
  logic [IDW-1:0]       win_id;
  logic [2*NUM_REQ-1:0] rot;
  int                   sum;
  logic                 owner_req;
  logic                 others_pend;
  logic                 hold_hit;
  logic [IDW-1:0]       rr_next;

  // rot[k] is req[(rr_q + k) mod NUM_REQ], so the lowest set bit is the winner.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    sum     = 0;
    rot     = {req, req} >> rr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_vld && rot[i]) begin
        win_vld = 1'b1;
        sum     = int'(rr_q) + i;
        win_id  = IDW'((sum >= NUM_REQ) ? (sum - NUM_REQ) : sum);
      end
    end
  end

  assign owner_req   = |(req & gnt_q);
  assign others_pend = |(req & ~gnt_q);
  assign hold_hit    = (hold_q == HCW'(MAX_HOLD));
  assign rr_next     = (int'(id_q) == NUM_REQ - 1) ? '0 : id_q + IDW'(1);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    ta_d    = ta_q;
    unique case (state_q)
      S_IDLE: begin
        gnt_d = '0;
        if (win_vld) begin
          gnt_d   = NUM_REQ'(1) << win_id;
          id_d    = win_id;
          hold_d  = HCW'(1);
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!owner_req || (hold_hit && others_pend)) begin
          gnt_d   = '0;
          rr_d    = rr_next;
          ta_d    = TCW'(TA_CYCLES - 1);
          state_d = S_TURN;
        end else if (!hold_hit) begin
          hold_d = hold_q + HCW'(1);
        end
      end
      S_TURN: begin
        gnt_d = '0;
        if (ta_q != '0) begin
          ta_d = ta_q - TCW'(1);
        end else if (win_vld) begin
          gnt_d   = NUM_REQ'(1) << win_id;
          id_d    = win_id;
          hold_d  = HCW'(1);
          state_d = S_GRANT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      rr_q    <= '0;
      hold_q  <= '0;
      ta_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
      ta_q    <= ta_d;
    end
  end

  assign gnt       = gnt_q;
  assign tri_en    = gnt_q;
  assign owner_id  = id_q;
  assign owner_vld = |gnt_q;
  assign state_dbg = state_q;

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
  a_req_known:   assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(req));

endmodule

// File: tb/tb_cpuc_bus_arbiter.sv
// Directed bench for cpuc_bus_arbiter: one instance with a 1-cycle gap, one with a
// 3-cycle gap; expected grants are queued per step and popped after the edge.
module tb_cpuc_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, req3;
  logic [3:0] gnt, tri_en, gnt3, tri_en3;
  logic [1:0] owner_id, owner_id3;
  logic       owner_vld, owner_vld3;
  logic [1:0] state_dbg, state_dbg3;

  int compared   = 0;
  int mismatched = 0;

  logic [3:0] exp_q[$];
  logic [3:0] exp3_q[$];
  logic [1:0] exp_id, exp_id3;

  // clock / reset
  always #5 clk = ~clk;

  cpuc_bus_arbiter #(.NUM_REQ(4), .MAX_HOLD(8), .TA_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .tri_en(tri_en),
    .owner_id(owner_id), .owner_vld(owner_vld), .state_dbg(state_dbg)
  );

  cpuc_bus_arbiter #(.NUM_REQ(4), .MAX_HOLD(8), .TA_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .gnt(gnt3), .tri_en(tri_en3),
    .owner_id(owner_id3), .owner_vld(owner_vld3), .state_dbg(state_dbg3)
  );

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    logic [1:0] r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // scoreboard: pop one expected grant per instance and compare all outputs
  task automatic compare_outputs();
    logic [3:0] e, e3;
    e  = exp_q.pop_front();
    e3 = exp3_q.pop_front();
    if (e != 4'd0)  exp_id  = idx_of(e);
    if (e3 != 4'd0) exp_id3 = idx_of(e3);
    check("gnt",        32'(gnt),        32'(e));
    check("tri_en",     32'(tri_en),     32'(e));
    check("owner_vld",  32'(owner_vld),  32'(|e));
    check("owner_id",   32'(owner_id),   32'(exp_id));
    check("gnt_ta3",    32'(gnt3),       32'(e3));
    check("tri_en_ta3", 32'(tri_en3),    32'(e3));
    check("owner_id_ta3", 32'(owner_id3), 32'(exp_id3));
  endtask

  // driver: apply requests, queue the grants expected after the next edge
  task automatic step(input logic [3:0] r, input logic [3:0] r3,
                      input logic [3:0] e, input logic [3:0] e3);
    req  = r;
    req3 = r3;
    exp_q.push_back(e);
    exp3_q.push_back(e3);
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic reset_check();
    exp_id  = 2'd0;
    exp_id3 = 2'd0;
    exp_q.push_back(4'd0);
    exp3_q.push_back(4'd0);
    compare_outputs();
  endtask

  // async reset pulse placed between clock edges
  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1 reset_check();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] oh;
    rst_n   = 1'b0;
    req     = 4'd0;
    req3    = 4'd0;
    exp_id  = 2'd0;
    exp_id3 = 2'd0;
    #3 reset_check();
    @(negedge clk) rst_n = 1'b1;

    // reset / idle
    repeat (10) step(4'd0, 4'd0, 4'd0, 4'd0);

    // single requester: grant, drop, re-raise inside the gap
    repeat (4) step(4'b0100, 4'd0, 4'b0100, 4'd0);
    step(4'd0,    4'd0, 4'd0,    4'd0);
    step(4'b0100, 4'd0, 4'b0100, 4'd0);
    step(4'd0,    4'd0, 4'd0,    4'd0);
    step(4'd0,    4'd0, 4'd0,    4'd0);

    // three-cycle gap: req[3] pulses in gap cycle 1, req[2] present at final gap edge
    step(4'd0, 4'b0010, 4'd0, 4'b0010);
    step(4'd0, 4'b0010, 4'd0, 4'b0010);
    step(4'd0, 4'd0,    4'd0, 4'd0);
    step(4'd0, 4'b1000, 4'd0, 4'd0);
    step(4'd0, 4'd0,    4'd0, 4'd0);
    step(4'd0, 4'b0100, 4'd0, 4'b0100);
    step(4'd0, 4'd0,    4'd0, 4'd0);
    repeat (3) step(4'd0, 4'd0, 4'd0, 4'd0);

    reset_pulse();

    // round robin with everyone requesting: 8-cycle tenures, 1 dead cycle
    for (int o = 0; o < 5; o++) begin
      oh = 4'b0001 << (o % 4);
      repeat (8) step(4'b1111, 4'd0, oh, 4'd0);
      step(4'b1111, 4'd0, 4'd0, 4'd0);
    end
    step(4'd0, 4'd0, 4'd0, 4'd0);

    // lone owner keeps the bus, then yields at the cap once req[2] appears
    repeat (30) step(4'b0001, 4'd0, 4'b0001, 4'd0);
    step(4'b0101, 4'd0, 4'd0, 4'd0);
    repeat (8) step(4'b0101, 4'd0, 4'b0100, 4'd0);
    step(4'b0101, 4'd0, 4'd0,    4'd0);
    step(4'b0101, 4'd0, 4'b0001, 4'd0);
    step(4'd0,    4'd0, 4'd0,    4'd0);
    step(4'd0,    4'd0, 4'd0,    4'd0);

    // move the round-robin pointer to 2, then reset while master 3 owns the bus
    step(4'b0010, 4'd0, 4'b0010, 4'd0);
    step(4'd0,    4'd0, 4'd0,    4'd0);
    step(4'd0,    4'd0, 4'd0,    4'd0);
    step(4'b1000, 4'd0, 4'b1000, 4'd0);
    step(4'b1000, 4'd0, 4'b1000, 4'd0);
    reset_pulse();
    step(4'b1010, 4'd0, 4'b0010, 4'd0);
    step(4'b1010, 4'd0, 4'b0010, 4'd0);
    step(4'd0,    4'd0, 4'd0,    4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
